// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall vector
// width, stall encodings, stall bit indices and FSM state codes.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  // Bit positions inside the stall vector (1 = hold that stage)
  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;
  localparam int STALL_WB     = 5;

  // A stall at stage X freezes X and everything upstream of it
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_mc_counter.sv
// Loadable down-counter sequencing multi-cycle EX operations.
// Clear wins over load, load wins over decrement; stops at zero.
module pipe_mc_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt_reg;

  // Counter register: reset/clear, load, or decrement toward zero
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign cnt    = cnt_reg;
  assign is_one = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Merges stall requests, sequences multi-cycle EX ops and issues a
// one-cycle flush with redirect PC on exceptions.
// Optional feature macro: STALL_PERF_EN (stall-cycle / flush counters).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              ex_mc_start,
  input  logic [CNT_W-1:0]  ex_mc_cycles,
  input  logic              excp_valid,
  input  logic [ADDR_W-1:0] excp_pc,
  output logic [5:0]        stall,
  output logic              ex_mc_done,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic [PERF_W-1:0] perf_stall_cyc,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  state_t            state_reg, state_next;
  logic              flush_reg;
  logic [ADDR_W-1:0] new_pc_reg;
  logic              cnt_clr, cnt_load, cnt_dec, cnt_is_one;
  logic [CNT_W-1:0]  cnt;
  logic              mc_short;

  assign mc_short = (ex_mc_cycles <= CNT_W'(1));

  pipe_mc_counter #(.CNT_W(CNT_W)) u_mc_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (ex_mc_cycles - CNT_W'(1)),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .is_one   (cnt_is_one)
  );

  // State register plus registered flush and redirect PC
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      flush_reg  <= 1'b0;
      new_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      flush_reg <= excp_valid;
      if (excp_valid) begin
        new_pc_reg <= excp_pc;
      end
    end
  end

  // Next state, counter control, stall vector and done flag
  always_comb begin
    state_next = state_reg;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    ex_mc_done = 1'b0;
    stall      = STALL_NONE;

    if (state_reg == ST_FLUSH) begin
      stall = STALL_NONE;
    end else if (stallreq_mem) begin
      stall = STALL_MEM;
    end else if (stallreq_ex || ex_mc_start || (state_reg == ST_MC_BUSY)) begin
      stall = STALL_EX;
    end else if (stallreq_id) begin
      stall = STALL_ID;
    end

    case (state_reg)
      ST_IDLE: begin
        if (excp_valid) begin
          state_next = ST_FLUSH;
          cnt_clr    = 1'b1;
        end else if (ex_mc_start) begin
          if (mc_short) begin
            ex_mc_done = 1'b1;
          end else begin
            cnt_load   = 1'b1;
            state_next = ST_MC_BUSY;
          end
        end
      end
      ST_MC_BUSY: begin
        if (excp_valid) begin
          // Aborted op never reports done
          state_next = ST_FLUSH;
          cnt_clr    = 1'b1;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_is_one) begin
            ex_mc_done = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        if (excp_valid) begin
          cnt_clr = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (rst) begin
      stall      = STALL_NONE;
      ex_mc_done = 1'b0;
    end
  end

  assign flush  = flush_reg;
  assign new_pc = new_pc_reg;

`ifdef STALL_PERF_EN
  logic [PERF_W-1:0] perf_stall_reg;
  logic [PERF_W-1:0] perf_flush_reg;

  // Saturating counters of PC-stall cycles and flush cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_reg <= '0;
      perf_flush_reg <= '0;
    end else begin
      if (stall[STALL_PC] && (perf_stall_reg != '1)) begin
        perf_stall_reg <= perf_stall_reg + PERF_W'(1);
      end
      if (flush_reg && (perf_flush_reg != '1)) begin
        perf_flush_reg <= perf_flush_reg + PERF_W'(1);
      end
    end
  end

  assign perf_stall_cyc = perf_stall_reg;
  assign perf_flush_cnt = perf_flush_reg;
`else
  assign perf_stall_cyc = '0;
  assign perf_flush_cnt = '0;
`endif

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: inputs change 1ns after posedge,
// outputs are checked on the following negedge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        excp_valid;
  logic [31:0] excp_pc;
  logic [5:0]  stall;
  logic        ex_mc_done;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .stallreq_mem   (stallreq_mem),
    .ex_mc_start    (ex_mc_start),
    .ex_mc_cycles   (ex_mc_cycles),
    .excp_valid     (excp_valid),
    .excp_pc        (excp_pc),
    .stall          (stall),
    .ex_mc_done     (ex_mc_done),
    .flush          (flush),
    .new_pc         (new_pc),
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check stall / done / flush / new_pc together, one line per cycle
  task automatic chk_all(input string tag, input logic [5:0] s, input logic d,
                         input logic f, input logic [31:0] pc);
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall), 32'(s));
    chk({tag, ".done"},  32'(ex_mc_done), 32'(d));
    chk({tag, ".flush"}, 32'(flush), 32'(f));
    chk({tag, ".new_pc"}, new_pc, pc);
    $display("step %-12s stall=%b done=%b flush=%b new_pc=%h", tag, stall, ex_mc_done, flush, new_pc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    ex_mc_start = 0; ex_mc_cycles = 0; excp_valid = 0; excp_pc = 0;
  endtask

  initial begin
    rst = 1;
    idle_in();
    stallreq_mem = 1;
    @(posedge clk); #1;
    // rst held: stall forced to zero even with a MEM request
    chk_all("reset", 6'b000000, 0, 0, 32'h0);
    @(negedge clk);
    chk("perf_stall_rst", perf_stall_cyc, 32'h0);
    chk("perf_flush_rst", perf_flush_cnt, 32'h0);
    @(posedge clk); #1;
    rst = 0; idle_in();
    chk_all("idle", 6'b000000, 0, 0, 32'h0);

    stallreq_id = 1;
    chk_all("id", 6'b000111, 0, 0, 32'h0);
    stallreq_id = 0;
    chk_all("id_after", 6'b000000, 0, 0, 32'h0);

    stallreq_id = 1; stallreq_mem = 1;
    chk_all("id_mem", 6'b011111, 0, 0, 32'h0);
    idle_in(); stallreq_ex = 1; stallreq_id = 1;
    chk_all("ex_id", 6'b001111, 0, 0, 32'h0);
    idle_in();

    // Multi-cycle N=4
    ex_mc_start = 1; ex_mc_cycles = 6'd4;
    chk_all("mc4_t0", 6'b001111, 0, 0, 32'h0);
    idle_in();
    chk_all("mc4_t1", 6'b001111, 0, 0, 32'h0);
    chk_all("mc4_t2", 6'b001111, 0, 0, 32'h0);
    chk_all("mc4_t3", 6'b001111, 1, 0, 32'h0);
    chk_all("mc4_t4", 6'b000000, 0, 0, 32'h0);

    // N=0 and N=1 are single-cycle
    ex_mc_start = 1; ex_mc_cycles = 6'd0;
    chk_all("mc0", 6'b001111, 1, 0, 32'h0);
    idle_in();
    chk_all("mc0_after", 6'b000000, 0, 0, 32'h0);
    ex_mc_start = 1; ex_mc_cycles = 6'd1;
    chk_all("mc1", 6'b001111, 1, 0, 32'h0);
    idle_in();
    chk_all("mc1_after", 6'b000000, 0, 0, 32'h0);

    // MEM stall during MC_BUSY widens vector, count continues (N=3)
    ex_mc_start = 1; ex_mc_cycles = 6'd3;
    chk_all("mc3_t0", 6'b001111, 0, 0, 32'h0);
    idle_in(); stallreq_mem = 1; ex_mc_start = 1; ex_mc_cycles = 6'd9;
    chk_all("mc3_t1_mem", 6'b011111, 0, 0, 32'h0);
    idle_in();
    chk_all("mc3_t2", 6'b001111, 1, 0, 32'h0);
    chk_all("mc3_t3", 6'b000000, 0, 0, 32'h0);

    // N=8 aborted by exception at T+2
    ex_mc_start = 1; ex_mc_cycles = 6'd8;
    chk_all("mc8_t0", 6'b001111, 0, 0, 32'h0);
    idle_in();
    chk_all("mc8_t1", 6'b001111, 0, 0, 32'h0);
    excp_valid = 1; excp_pc = 32'h0000_0040;
    chk_all("mc8_t2_excp", 6'b001111, 0, 0, 32'h0);
    idle_in(); stallreq_mem = 1;
    chk_all("mc8_t3_flush", 6'b000000, 0, 1, 32'h40);
    idle_in();
    chk_all("mc8_t4_idle", 6'b000000, 0, 0, 32'h40);

    // Back-to-back exceptions: FLUSH re-latches new_pc
    excp_valid = 1; excp_pc = 32'h0000_1000;
    chk_all("excpA", 6'b000000, 0, 0, 32'h40);
    excp_pc = 32'h0000_2000;
    chk_all("excpB_flush", 6'b000000, 0, 1, 32'h1000);
    idle_in();
    chk_all("excpB_flush2", 6'b000000, 0, 1, 32'h2000);
    chk_all("excp_done", 6'b000000, 0, 0, 32'h2000);

    // Exception outranks start in the same cycle
    excp_valid = 1; excp_pc = 32'h0000_0300; ex_mc_start = 1; ex_mc_cycles = 6'd1;
    chk_all("excp_start", 6'b001111, 0, 0, 32'h2000);
    idle_in();
    chk_all("excp_start_f", 6'b000000, 0, 1, 32'h300);
    chk_all("excp_start_i", 6'b000000, 0, 0, 32'h300);

    // Reset during MC_BUSY
    ex_mc_start = 1; ex_mc_cycles = 6'd8;
    chk_all("rst_mc_t0", 6'b001111, 0, 0, 32'h300);
    idle_in(); rst = 1; stallreq_ex = 1;
    chk_all("rst_mc_t1", 6'b000000, 0, 0, 32'h300);
    rst = 0; idle_in();
    chk_all("rst_mc_t2", 6'b000000, 0, 0, 32'h0);
    @(negedge clk);
    chk("perf_stall_rst2", perf_stall_cyc, 32'h0);
    chk("perf_flush_rst2", perf_flush_cnt, 32'h0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
